// File: rtl/locker_ctrl.sv
// locker_ctrl: combination-lock controller for the Locker design.
//
// Digits arrive as a latched 4-bit KEY value with a latched valid level KEY_V
// from the D_EN key stage. A digit is accepted on the rising edge of KEY_V,
// which is detected against a registered copy of KEY_V. The controller
// collects DIGITS digits, compares them with the stored code, and then opens
// the door, counts a failure, or enters a timed lockout. While the door is
// open, PROG starts reprogramming of the stored code and LOCK closes the door
// or aborts programming.
//
// Ports:
//   C            in   clock, rising edge
//   CLRn         in   asynchronous active-low reset
//   KEY[3:0]     in   latched key value
//   KEY_V        in   latched key-valid level
//   PROG         in   request code change (honoured only while open)
//   LOCK         in   close door / abort programming
//   OPEN         out  door open (registered)
//   ALARM        out  lockout active (registered)
//   DIG_CNT[2:0] out  digits collected in the current entry
//   FAIL_CNT[1:0] out consecutive failed codes
//   dbg_state_o  out  current FSM state (0 IDLE, 1 CHECK, 2 OPEN, 3 PRG, 4 LOCKOUT)
//
// Handshake: there is no valid/ready pairing on this block. KEY_V is a level;
// one digit is taken per low-to-high transition of KEY_V seen at a rising
// edge of C, with KEY sampled at that same edge. The block never stalls the
// key stage; digits arriving in CHECK, OPEN or LOCKOUT are dropped.
module locker_ctrl #(
  parameter int          DIGITS       = 4,
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int          MAX_FAIL     = 3,
  parameter int          OPEN_CYC     = 500,
  parameter int          LOCKOUT_CYC  = 1000
) (
  input  logic       C,
  input  logic       CLRn,
  input  logic [3:0] KEY,
  input  logic       KEY_V,
  input  logic       PROG,
  input  logic       LOCK,
  output logic       OPEN,
  output logic       ALARM,
  output logic [2:0] DIG_CNT,
  output logic [1:0] FAIL_CNT,
  output logic [2:0] dbg_state_o
);

  localparam int          CW        = 4 * DIGITS;
  localparam logic [2:0]  DIG_LAST  = 3'(DIGITS);
  localparam logic [2:0]  FAIL_LIM  = 3'(MAX_FAIL);
  localparam logic [15:0] OPEN_LOAD = 16'(OPEN_CYC - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_PRG     = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   code_q, code_d;
  logic [2:0]      dig_cnt_q, dig_cnt_d;
  logic [1:0]      fail_cnt_q, fail_cnt_d;
  logic [15:0]     timer_q, timer_d;
  logic            kv_q;
  logic            open_q, open_d;
  logic            alarm_q, alarm_d;

  logic            accept;
  logic [CW-1:0]   entry_shift;
  logic [2:0]      dig_inc;
  logic [2:0]      fail_inc;

  assign accept      = KEY_V & ~kv_q;
  assign entry_shift = {entry_q[CW-5:0], KEY};
  assign dig_inc     = dig_cnt_q + 3'd1;
  // One bit wider than FAIL_CNT so the compare with the limit cannot wrap.
  assign fail_inc    = {1'b0, fail_cnt_q} + 3'd1;

  // State and datapath registers.
  always_ff @(posedge C or negedge CLRn) begin
    if (!CLRn) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      // Digit 0 sits in the top nibble of the default code.
      code_q     <= DEFAULT_CODE[15 -: CW];
      dig_cnt_q  <= 3'd0;
      fail_cnt_q <= 2'd0;
      timer_q    <= 16'd0;
      kv_q       <= 1'b0;
      open_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      code_q     <= code_d;
      dig_cnt_q  <= dig_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
      kv_q       <= KEY_V;
      open_q     <= open_d;
      alarm_q    <= alarm_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    code_d     = code_q;
    dig_cnt_d  = dig_cnt_q;
    fail_cnt_d = fail_cnt_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          entry_d   = entry_shift;
          dig_cnt_d = dig_inc;
          if (dig_inc == DIG_LAST) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        dig_cnt_d = 3'd0;
        if (entry_q == code_q) begin
          fail_cnt_d = 2'd0;
          timer_d    = OPEN_LOAD;
          state_d    = S_OPEN;
        end else if (fail_inc < FAIL_LIM) begin
          fail_cnt_d = fail_inc[1:0];
          state_d    = S_IDLE;
        end else begin
          fail_cnt_d = FAIL_LIM[1:0];
          timer_d    = LOCK_LOAD;
          state_d    = S_LOCKOUT;
        end
      end
      S_OPEN: begin
        if (LOCK) begin
          state_d = S_IDLE;
        end else if (timer_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
          if (PROG) begin
            dig_cnt_d = 3'd0;
            state_d   = S_PRG;
          end
        end
      end
      S_PRG: begin
        // LOCK outranks a digit arriving in the same cycle.
        if (LOCK) begin
          dig_cnt_d = 3'd0;
          state_d   = S_IDLE;
        end else if (accept) begin
          entry_d = entry_shift;
          if (dig_inc == DIG_LAST) begin
            code_d    = entry_shift;
            dig_cnt_d = 3'd0;
            state_d   = S_IDLE;
          end else begin
            dig_cnt_d = dig_inc;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == 16'd0) begin
          fail_cnt_d = 2'd0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the current state and are registered, which puts OPEN and
  // ALARM two edges after the edge that accepts the final digit.
  always_comb begin
    open_d  = (state_q == S_OPEN) || (state_q == S_PRG);
    alarm_d = (state_q == S_LOCKOUT);
  end

  assign OPEN        = open_q;
  assign ALARM       = alarm_q;
  assign DIG_CNT     = dig_cnt_q;
  assign FAIL_CNT    = fail_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Testbench for locker_ctrl with OPEN_CYC=8 and LOCKOUT_CYC=16.
module tb_locker_ctrl;

  logic       C;
  logic       CLRn;
  logic [3:0] KEY;
  logic       KEY_V;
  logic       PROG;
  logic       LOCK;
  logic       OPEN;
  logic       ALARM;
  logic [2:0] DIG_CNT;
  logic [1:0] FAIL_CNT;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRG  = 3'd3;

  locker_ctrl #(
    .DIGITS      (4),
    .DEFAULT_CODE(16'h1234),
    .MAX_FAIL    (3),
    .OPEN_CYC    (8),
    .LOCKOUT_CYC (16)
  ) dut (
    .C          (C),
    .CLRn       (CLRn),
    .KEY        (KEY),
    .KEY_V      (KEY_V),
    .PROG       (PROG),
    .LOCK       (LOCK),
    .OPEN       (OPEN),
    .ALARM      (ALARM),
    .DIG_CNT    (DIG_CNT),
    .FAIL_CNT   (FAIL_CNT),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard helper.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks. All drive on the falling edge so the DUT samples mid-cycle.
  task automatic do_reset();
    CLRn  = 1'b0;
    KEY   = 4'd0;
    KEY_V = 1'b0;
    PROG  = 1'b0;
    LOCK  = 1'b0;
    repeat (2) @(negedge C);
    CLRn = 1'b1;
    @(negedge C);
  endtask

  // One-cycle KEY_V pulse; returns on the negedge right after the accepting edge.
  task automatic pulse_key(input logic [3:0] k);
    @(negedge C);
    KEY   = k;
    KEY_V = 1'b1;
    @(negedge C);
    KEY_V = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c, input bit chk_cnt);
    for (int i = 0; i < 4; i++) begin
      pulse_key(c[15-4*i -: 4]);
      if (chk_cnt && i < 3) check("dig_cnt_step", DIG_CNT, 32'(i + 1));
    end
  endtask

  // Enter a full code and stop on the negedge after OPEN/ALARM should react.
  task automatic enter_and_settle(input logic [15:0] c);
    enter_code(c, 1'b0);
    repeat (2) @(negedge C);
  endtask

  task automatic pulse_prog();
    @(negedge C);
    PROG = 1'b1;
    @(negedge C);
    PROG = 1'b0;
  endtask

  task automatic pulse_lock();
    @(negedge C);
    LOCK = 1'b1;
    @(negedge C);
    LOCK = 1'b0;
  endtask

  // Table of code attempts from reset: expected outputs two edges after the
  // final digit.
  typedef struct packed {
    logic [15:0] code;
    logic        exp_open;
    logic        exp_alarm;
    logic [1:0]  exp_fail;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    bit bad;

    vecs[0] = '{16'h1234, 1'b1, 1'b0, 2'd0};
    vecs[1] = '{16'h0000, 1'b0, 1'b0, 2'd1};
    vecs[2] = '{16'h1235, 1'b0, 1'b0, 2'd2};
    vecs[3] = '{16'h1234, 1'b1, 1'b0, 2'd0};
    vecs[4] = '{16'h4321, 1'b0, 1'b0, 2'd1};
    vecs[5] = '{16'h0000, 1'b0, 1'b0, 2'd2};
    vecs[6] = '{16'h0000, 1'b0, 1'b1, 2'd3};
    vecs[7] = '{16'h1234, 1'b1, 1'b0, 2'd0};

    // Reset state.
    do_reset();
    check("reset_open", OPEN, 0);
    check("reset_alarm", ALARM, 0);
    check("reset_dig_cnt", DIG_CNT, 0);
    check("reset_fail_cnt", FAIL_CNT, 0);
    check("reset_state", dbg_state, ST_IDLE);

    // Table-driven code attempts.
    for (int v = 0; v < 8; v++) begin
      enter_code(vecs[v].code, 1'b1);
      repeat (2) @(negedge C);
      check("vec_open", OPEN, vecs[v].exp_open);
      check("vec_alarm", ALARM, vecs[v].exp_alarm);
      check("vec_fail_cnt", FAIL_CNT, vecs[v].exp_fail);
      check("vec_dig_cnt", DIG_CNT, 0);
      if (vecs[v].exp_open) begin
        pulse_lock();
        @(negedge C);
        check("vec_lock_closes", OPEN, 0);
      end
      if (vecs[v].exp_alarm) begin
        for (int i = 0; i < 40; i++) begin
          if (!ALARM) break;
          @(negedge C);
        end
        check("vec_alarm_ends", ALARM, 0);
        check("vec_alarm_fail_clr", FAIL_CNT, 0);
      end
      repeat (2) @(negedge C);
    end

    // Correct code: latency and exact open duration.
    do_reset();
    enter_code(16'h1234, 1'b1);
    check("open_not_yet", OPEN, 0);
    @(negedge C);
    check("open_one_edge", OPEN, 0);
    check("dig_cnt_cleared", DIG_CNT, 0);
    @(negedge C);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!OPEN) break;
      cnt++;
      @(negedge C);
    end
    check("open_duration", cnt, 8);
    check("open_fail_cnt", FAIL_CNT, 0);
    check("open_back_idle", dbg_state, ST_IDLE);

    // Held KEY_V accepts once; then a wrong code.
    do_reset();
    @(negedge C);
    KEY   = 4'd1;
    KEY_V = 1'b1;
    repeat (5) @(negedge C);
    KEY_V = 1'b0;
    check("hold_once", DIG_CNT, 1);
    pulse_key(4'd2);
    pulse_key(4'd3);
    pulse_key(4'd5);
    repeat (2) @(negedge C);
    check("wrong_fail_cnt", FAIL_CNT, 1);
    check("wrong_state", dbg_state, ST_IDLE);
    check("wrong_open", OPEN, 0);

    // Lockout: length, digits ignored, recovery.
    do_reset();
    enter_and_settle(16'h0000);
    enter_and_settle(16'h0000);
    enter_and_settle(16'h0000);
    check("lockout_alarm", ALARM, 1);
    check("lockout_fail_cnt", FAIL_CNT, 3);
    check("lockout_no_open", OPEN, 0);
    cnt = 0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!ALARM) break;
      cnt++;
      if (DIG_CNT != 3'd0) bad = 1'b1;
      KEY   = 4'd5;
      KEY_V = (i < 10) && ((i % 4) < 2);
      @(negedge C);
    end
    KEY_V = 1'b0;
    check("alarm_duration", cnt, 16);
    check("alarm_digits_ignored", bad, 0);
    check("alarm_fail_clr", FAIL_CNT, 0);
    check("alarm_dig_cnt", DIG_CNT, 0);
    repeat (2) @(negedge C);
    enter_and_settle(16'h1234);
    check("after_lockout_open", OPEN, 1);

    // Reprogramming to 9876.
    do_reset();
    enter_and_settle(16'h1234);
    check("prg_open", OPEN, 1);
    pulse_prog();
    check("prg_state", dbg_state, ST_PRG);
    check("prg_open_held", OPEN, 1);
    check("prg_dig_cnt", DIG_CNT, 0);
    enter_code(16'h9876, 1'b1);
    check("prg_done_state", dbg_state, ST_IDLE);
    check("prg_done_dig", DIG_CNT, 0);
    @(negedge C);
    check("prg_door_closes", OPEN, 0);
    repeat (2) @(negedge C);
    enter_and_settle(16'h1234);
    check("old_code_fails", FAIL_CNT, 1);
    check("old_code_closed", OPEN, 0);
    enter_and_settle(16'h9876);
    check("new_code_opens", OPEN, 1);
    check("new_code_fail_clr", FAIL_CNT, 0);

    // PROG with LOCK, partial programming, LOCK with final digit.
    do_reset();
    enter_and_settle(16'h1234);
    @(negedge C);
    PROG = 1'b1;
    LOCK = 1'b1;
    @(negedge C);
    PROG = 1'b0;
    LOCK = 1'b0;
    check("prog_lock_state", dbg_state, ST_IDLE);
    @(negedge C);
    check("prog_lock_closed", OPEN, 0);
    enter_and_settle(16'h1234);
    check("abort_reopen", OPEN, 1);
    pulse_prog();
    pulse_key(4'd5);
    check("abort_dig1", DIG_CNT, 1);
    pulse_key(4'd5);
    check("abort_dig2", DIG_CNT, 2);
    pulse_lock();
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_dig_clr", DIG_CNT, 0);
    repeat (2) @(negedge C);
    enter_and_settle(16'h1234);
    check("abort_code_kept", OPEN, 1);
    pulse_prog();
    pulse_key(4'd1);
    pulse_key(4'd1);
    pulse_key(4'd1);
    @(negedge C);
    KEY   = 4'd7;
    KEY_V = 1'b1;
    LOCK  = 1'b1;
    @(negedge C);
    KEY_V = 1'b0;
    LOCK  = 1'b0;
    check("lock_wins_state", dbg_state, ST_IDLE);
    check("lock_wins_dig", DIG_CNT, 0);
    repeat (2) @(negedge C);
    enter_and_settle(16'h1234);
    check("lock_wins_code_kept", OPEN, 1);
    check("lock_wins_fail", FAIL_CNT, 0);

    // Asynchronous reset mid-entry and after reprogramming.
    do_reset();
    pulse_key(4'd1);
    pulse_key(4'd2);
    check("pre_reset_dig", DIG_CNT, 2);
    @(posedge C);
    #2 CLRn = 1'b0;
    #1;
    check("async_dig_clr", DIG_CNT, 0);
    check("async_open_clr", OPEN, 0);
    check("async_alarm_clr", ALARM, 0);
    check("async_fail_clr", FAIL_CNT, 0);
    @(negedge C);
    CLRn = 1'b1;
    pulse_key(4'd3);
    pulse_key(4'd4);
    repeat (2) @(negedge C);
    check("post_reset_dig", DIG_CNT, 2);
    check("post_reset_no_open", OPEN, 0);

    do_reset();
    enter_and_settle(16'h1234);
    pulse_prog();
    enter_code(16'h9876, 1'b0);
    repeat (2) @(negedge C);
    enter_and_settle(16'h9876);
    check("reprog_open", OPEN, 1);
    @(posedge C);
    #2 CLRn = 1'b0;
    #1;
    check("async_open_drop", OPEN, 0);
    @(negedge C);
    CLRn = 1'b1;
    enter_and_settle(16'h1234);
    check("default_restored", OPEN, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
